// File: rtl/multi_channel_input_synchronizer_pkg.sv
// sync_pkg: legal parameter ranges and counter sizing shared by the synchronizer files
package sync_pkg;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILTER_MAX = 255;
  function automatic int cnt_width(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/multi_channel_input_synchronizer_if.sv
// multi_channel_input_synchronizer_if: async inputs in; filtered level, rise/fall/any_change pulses out
// optional (SYNC_GLITCH_DETECT_EN): clear_glitch in, glitch_seen out
interface multi_channel_input_synchronizer_if #(parameter int WIDTH = 10);
  logic [WIDTH-1:0] async_in;
  logic [WIDTH-1:0] level_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;
  logic any_change;
`ifdef SYNC_GLITCH_DETECT_EN
  logic clear_glitch;
  logic [WIDTH-1:0] glitch_seen;
  modport master (output async_in, clear_glitch, input level_out, rise_out, fall_out, any_change, glitch_seen);
  modport slave (input async_in, clear_glitch, output level_out, rise_out, fall_out, any_change, glitch_seen);
`else
  modport master (output async_in, input level_out, rise_out, fall_out, any_change);
  modport slave (input async_in, output level_out, rise_out, fall_out, any_change);
`endif
endinterface

// File: rtl/multi_channel_input_synchronizer_filter_channel.sv
// sync_filter_channel: one bit's synchronizer chain, stability filter and edge pulses
// ports: clk, n_reset, async_in -> level, rise, fall; SYNC_GLITCH_DETECT_EN adds clear_glitch -> glitch_seen
module sync_filter_channel import sync_pkg::*; #(
  parameter int STAGES = 2,
  parameter int FILTER_CYCLES = 3,
  parameter logic RESET_VAL = 1'b0
) (
  input logic clk,
  input logic n_reset,
  input logic async_in,
`ifdef SYNC_GLITCH_DETECT_EN
  input logic clear_glitch,
  output logic glitch_seen,
`endif
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
  logic [STAGES-1:0] stage;
  logic [CW-1:0] cnt;
  logic differ, done;
  always_comb begin
    differ = stage[STAGES-1] != level;
    done = differ && cnt == LAST;
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      stage <= {STAGES{RESET_VAL}};
      cnt <= '0;
      level <= RESET_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      stage <= {stage[STAGES-2:0], async_in};
      cnt <= done || !differ ? '0 : cnt + 1'b1;
      level <= done ? stage[STAGES-1] : level;
      rise <= done && stage[STAGES-1];
      fall <= done && !stage[STAGES-1];
    end
`ifdef SYNC_GLITCH_DETECT_EN
  // a nonzero count that falls back to the current level is a rejected glitch
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) glitch_seen <= 1'b0;
    else glitch_seen <= (cnt != '0 && !differ) || (glitch_seen && !clear_glitch);
`endif
endmodule

// File: rtl/multi_channel_input_synchronizer.sv
// multi_channel_input_synchronizer: WIDTH async inputs synchronized and glitch-filtered into clk
// ports: clk, n_reset (async active-low), bus (slave: async_in -> level_out, rise_out, fall_out, any_change)
// macro SYNC_GLITCH_DETECT_EN adds bus.clear_glitch / bus.glitch_seen
module multi_channel_input_synchronizer import sync_pkg::*; #(
  parameter int WIDTH = 10,
  parameter int STAGES = 2,
  parameter int FILTER_CYCLES = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic n_reset,
  multi_channel_input_synchronizer_if.slave bus
);
  logic [WIDTH-1:0] level, rise, fall;
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("STAGES must be within 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > FILTER_MAX) begin : g_bad_filter
    $error("FILTER_CYCLES must be within 1..255");
  end
`ifdef SYNC_GLITCH_DETECT_EN
  logic [WIDTH-1:0] glitch;
  assign bus.glitch_seen = glitch;
`endif
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_channel #(
      .STAGES(STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL(RESET_VAL[i])
    ) u_ch (
      .clk(clk),
      .n_reset(n_reset),
      .async_in(bus.async_in[i]),
`ifdef SYNC_GLITCH_DETECT_EN
      .clear_glitch(bus.clear_glitch),
      .glitch_seen(glitch[i]),
`endif
      .level(level[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  assign bus.level_out = level;
  assign bus.rise_out = rise;
  assign bus.fall_out = fall;
  assign bus.any_change = |(rise | fall);
endmodule
